// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master, one-slave AXI4 arbiter: IFU (M0, read) and LSU (M1, read/write)
// share one slave port, one whole transaction at a time, LSU favoured.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   m0_ar*, m0_r*       : IFU read address / read data channels
//   m1_ar*, m1_r*       : LSU read address / read data channels
//   m1_aw*, m1_w*, m1_b*: LSU write address / write data / write response
//   s_*                 : slave port towards memory (mirrored directions)
//   grant               : owner, 00 none, 01 M0 read, 10 M1 read, 11 M1 write
module ysyx_24100029_axi_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [ID_W-1:0]     m0_arid,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rlast,
   output logic [ID_W-1:0]     m0_rid,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [ID_W-1:0]     m1_arid,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rlast,
   output logic [ID_W-1:0]     m1_rid,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [1:0]          m1_bresp,
   output logic [ID_W-1:0]     m1_bid,
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [ID_W-1:0]     s_arid,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   input  logic                s_rvalid,
   output logic                s_rready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rlast,
   input  logic [ID_W-1:0]     s_rid,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [ID_W-1:0]     s_awid,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   input  logic                s_bvalid,
   output logic                s_bready,
   input  logic [1:0]          s_bresp,
   input  logic [ID_W-1:0]     s_bid,
   output logic [1:0]          grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      M0_RD = 2'b01,
      M1_RD = 2'b10,
      M1_WR = 2'b11
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_ar_done;
   logic   r_aw_done;
   logic   r_w_done;
   logic   w_ar_hs;
   logic   w_aw_hs;
   logic   w_w_hs;

   assign grant   = r_state;
   assign w_ar_hs = s_arvalid & s_arready;
   assign w_aw_hs = s_awvalid & s_awready;
   // Only the final beat marks the write data phase complete.
   assign w_w_hs  = s_wvalid & s_wready & s_wlast;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ar_done <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == IDLE) begin
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_ar_hs) r_ar_done <= 1'b1;
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rlast   = 1'b0;
      m0_rid     = '0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rlast   = 1'b0;
      m1_rid     = '0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = '0;
      m1_bid     = '0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_arsize   = '0;
      s_arburst  = '0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awid     = '0;
      s_awlen    = '0;
      s_awsize   = '0;
      s_awburst  = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      unique case (r_state)
         IDLE: begin
            // A write request wins even before its data is valid.
            if (m1_awvalid)      w_next = M1_WR;
            else if (m1_arvalid) w_next = M1_RD;
            else if (m0_arvalid) w_next = M0_RD;
         end
         M0_RD: begin
            s_arvalid  = m0_arvalid & ~r_ar_done;
            s_araddr   = m0_araddr;
            s_arid     = m0_arid;
            s_arlen    = m0_arlen;
            s_arsize   = m0_arsize;
            s_arburst  = m0_arburst;
            m0_arready = s_arready & ~r_ar_done;
            m0_rvalid  = s_rvalid;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            m0_rlast   = s_rlast;
            m0_rid     = s_rid;
            s_rready   = m0_rready;
            if (s_rvalid & m0_rready & s_rlast) w_next = IDLE;
         end
         M1_RD: begin
            s_arvalid  = m1_arvalid & ~r_ar_done;
            s_araddr   = m1_araddr;
            s_arid     = m1_arid;
            s_arlen    = m1_arlen;
            s_arsize   = m1_arsize;
            s_arburst  = m1_arburst;
            m1_arready = s_arready & ~r_ar_done;
            m1_rvalid  = s_rvalid;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            m1_rlast   = s_rlast;
            m1_rid     = s_rid;
            s_rready   = m1_rready;
            if (s_rvalid & m1_rready & s_rlast) w_next = IDLE;
         end
         M1_WR: begin
            s_awvalid  = m1_awvalid & ~r_aw_done;
            s_awaddr   = m1_awaddr;
            s_awid     = m1_awid;
            s_awlen    = m1_awlen;
            s_awsize   = m1_awsize;
            s_awburst  = m1_awburst;
            m1_awready = s_awready & ~r_aw_done;
            s_wvalid   = m1_wvalid & ~r_w_done;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wlast    = m1_wlast;
            m1_wready  = s_wready & ~r_w_done;
            // B is forwarded regardless of the AW/W flags.
            m1_bvalid  = s_bvalid;
            m1_bresp   = s_bresp;
            m1_bid     = s_bid;
            s_bready   = m1_bready;
            if (s_bvalid & m1_bready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// Bench for ysyx_24100029_axi_arbiter: directed masters, a scripted slave,
// and a scoreboard monitor checking every handshake against queued values.
module tb_ysyx_24100029_axi_arbiter;

   logic        clock, reset;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [31:0] m0_araddr, m0_rdata;
   logic [3:0]  m0_arid, m0_rid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [31:0] m1_araddr, m1_rdata;
   logic [3:0]  m1_arid, m1_rid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
   logic [31:0] m1_awaddr, m1_wdata;
   logic [3:0]  m1_awid, m1_wstrb, m1_bid;
   logic [7:0]  m1_awlen;
   logic [2:0]  m1_awsize;
   logic [1:0]  m1_awburst, m1_bresp;
   logic        m1_bvalid, m1_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [3:0]  s_arid, s_rid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst, s_rresp;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic [31:0] s_awaddr, s_wdata;
   logic [3:0]  s_awid, s_wstrb, s_bid;
   logic [7:0]  s_awlen;
   logic [2:0]  s_awsize;
   logic [1:0]  s_awburst, s_bresp;
   logic        s_bvalid, s_bready;
   logic [1:0]  grant;

   logic sl_arready, sl_awready, sl_wready;
   assign s_arready = sl_arready;
   assign s_awready = sl_awready;
   assign s_wready  = sl_wready;

   int n_checks, n_fail;
   int cnt_aw, cnt_w;
   logic [63:0] exp_ar[$], exp_r0[$], exp_r1[$];
   logic [63:0] exp_aw[$], exp_w[$], exp_b[$];
   logic [33:0] sl_r[$];
   logic [63:0] e;

   bit          ar_hs, aw_hs, w_hs, r_hs, b_hs, rst_s;
   bit          got_aw, got_w;
   logic [7:0]  c_len;
   logic [3:0]  c_rid, c_bid;
   logic [33:0] beat;
   int          rem;

   ysyx_24100029_axi_arbiter dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
      .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
      .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
      .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .m1_bresp(m1_bresp), .m1_bid(m1_bid),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_bresp(s_bresp), .s_bid(s_bid),
      .grant(grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push_ar(input bit sel, input logic [31:0] a,
                          input logic [3:0] id, input logic [7:0] len);
      exp_ar.push_back({13'b0, (sel ? 2'b10 : 2'b01), a, id, len,
                        3'd2, 2'b01});
   endtask

   task automatic rd_beat(input bit sel, input logic [31:0] d,
                          input logic [1:0] rs, input bit last,
                          input logic [3:0] id);
      sl_r.push_back({rs, d});
      if (sel) exp_r1.push_back({25'b0, d, rs, last, id});
      else     exp_r0.push_back({25'b0, d, rs, last, id});
   endtask

   task automatic mrd(input bit sel, input logic [31:0] a,
                      input logic [3:0] id, input logic [7:0] len);
      int n;
      bit hs, done;
      if (sel) begin
         m1_araddr = a; m1_arid = id; m1_arlen = len;
         m1_arsize = 3'd2; m1_arburst = 2'b01;
         m1_arvalid = 1'b1; m1_rready = 1'b1;
      end else begin
         m0_araddr = a; m0_arid = id; m0_arlen = len;
         m0_arsize = 3'd2; m0_arburst = 2'b01;
         m0_arvalid = 1'b1; m0_rready = 1'b1;
      end
      n = 0; hs = 0;
      while (!hs && n < 40) begin
         @(negedge clock);
         hs = sel ? m1_arready : m0_arready;
         n++;
         tick();
      end
      if (sel) m1_arvalid = 1'b0;
      else     m0_arvalid = 1'b0;
      chk("ar_accept", 64'(hs), 64'd1);
      n = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clock);
         done = sel ? (m1_rvalid && m1_rready && m1_rlast)
                    : (m0_rvalid && m0_rready && m0_rlast);
         n++;
         tick();
      end
      chk("r_complete", 64'(done), 64'd1);
   endtask

   task automatic mwr(input logic [31:0] a, input logic [3:0] id,
                      input logic [31:0] d, input logic [3:0] st);
      int n;
      bit aw_ok, w_ok, done;
      m1_awaddr = a; m1_awid = id; m1_awlen = 8'd0;
      m1_awsize = 3'd0; m1_awburst = 2'b01;
      m1_wdata = d; m1_wstrb = st; m1_wlast = 1'b1;
      m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_bready = 1'b1;
      n = 0; aw_ok = 0; w_ok = 0;
      while (!(aw_ok && w_ok) && n < 40) begin
         @(negedge clock);
         if (m1_awready) aw_ok = 1;
         if (m1_wready)  w_ok = 1;
         n++;
         tick();
      end
      m1_awvalid = 1'b0; m1_wvalid = 1'b0;
      chk("aw_w_accept", 64'({aw_ok, w_ok}), 64'd3);
      n = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clock);
         done = m1_bvalid && m1_bready;
         n++;
         tick();
      end
      chk("b_complete", 64'(done), 64'd1);
   endtask

   initial begin
      int a0, w0;
      n_checks = 0; n_fail = 0; cnt_aw = 0; cnt_w = 0;
      reset = 1'b1;
      m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0;
      m0_arsize = 0; m0_arburst = 0; m0_rready = 0;
      m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0;
      m1_arsize = 0; m1_arburst = 0; m1_rready = 0;
      m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0;
      m1_awsize = 0; m1_awburst = 0;
      m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0;
      m1_bready = 0;
      sl_arready = 1; sl_awready = 1; sl_wready = 1;
      s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
      s_bvalid = 0; s_bresp = 0; s_bid = 0;
      rem = 0; got_aw = 0; got_w = 0;
      c_len = 0; c_rid = 0; c_bid = 0;
      fork
         // scripted slave
         forever begin
            @(negedge clock);
            ar_hs = s_arvalid && s_arready;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready && s_wlast;
            r_hs  = s_rvalid && s_rready;
            b_hs  = s_bvalid && s_bready;
            rst_s = reset;
            if (ar_hs) begin c_len = s_arlen; c_rid = s_arid; end
            if (aw_hs) c_bid = s_awid;
            tick();
            if (rst_s) begin
               rem = 0; s_rvalid = 0; s_bvalid = 0;
               got_aw = 0; got_w = 0;
            end else begin
               if (r_hs) begin
                  rem--;
                  if (rem == 0) s_rvalid = 0;
               end
               if (ar_hs) rem = int'(c_len) + 1;
               if (rem > 0 && (!s_rvalid || r_hs)) begin
                  beat = (sl_r.size() > 0) ? sl_r.pop_front()
                                           : 34'h0_dead_beef;
                  s_rdata = beat[31:0];
                  s_rresp = beat[33:32];
                  s_rlast = (rem == 1);
                  s_rid = c_rid;
                  s_rvalid = 1;
               end
               if (aw_hs) got_aw = 1;
               if (w_hs)  got_w = 1;
               if (b_hs) begin
                  s_bvalid = 0; got_aw = 0; got_w = 0;
               end
               if (got_aw && got_w && !s_bvalid) begin
                  s_bvalid = 1; s_bresp = 2'b00; s_bid = c_bid;
               end
            end
         end
         // scoreboard monitor
         forever begin
            @(negedge clock);
            if (!reset) begin
               if (s_arvalid && s_arready) begin
                  if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_ar.pop_front();
                     chk("ar", {13'b0, grant, s_araddr, s_arid, s_arlen,
                                s_arsize, s_arburst}, e);
                  end
               end
               if (m0_rvalid && m0_rready) begin
                  if (exp_r0.size() == 0) chk("r0_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_r0.pop_front();
                     chk("r0", {25'b0, m0_rdata, m0_rresp, m0_rlast, m0_rid}, e);
                  end
               end
               if (m1_rvalid && m1_rready) begin
                  if (exp_r1.size() == 0) chk("r1_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_r1.pop_front();
                     chk("r1", {25'b0, m1_rdata, m1_rresp, m1_rlast, m1_rid}, e);
                  end
               end
               if (s_awvalid && s_awready) begin
                  cnt_aw++;
                  if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_aw.pop_front();
                     chk("aw", {13'b0, grant, s_awaddr, s_awid, s_awlen,
                                s_awsize, s_awburst}, e);
                  end
               end
               if (s_wvalid && s_wready) begin
                  cnt_w++;
                  if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_w.pop_front();
                     chk("w", {27'b0, s_wdata, s_wstrb, s_wlast}, e);
                  end
               end
               if (m1_bvalid && m1_bready) begin
                  if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                  else begin
                     e = exp_b.pop_front();
                     chk("b", {58'b0, m1_bresp, m1_bid}, e);
                  end
               end
               if (m0_arvalid && grant != 2'b01)
                  chk("m0_arready_blocked", 64'(m0_arready), 64'd0);
               if (m1_arvalid && grant != 2'b10)
                  chk("m1_arready_blocked", 64'(m1_arready), 64'd0);
            end
         end
         // directed stimulus
         begin
            repeat (3) tick();
            @(negedge clock);
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
            chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
            chk("rst_s_wvalid", 64'(s_wvalid), 64'd0);
            chk("rst_s_rready", 64'(s_rready), 64'd0);
            chk("rst_s_bready", 64'(s_bready), 64'd0);
            chk("rst_m_readies", 64'({m0_arready, m1_arready,
                                      m1_awready, m1_wready}), 64'd0);
            chk("rst_m_valids", 64'({m0_rvalid, m1_rvalid, m1_bvalid}), 64'd0);
            chk("rst_s_araddr", 64'(s_araddr), 64'd0);
            tick();
            reset = 1'b0;
            tick();

            // single IFU read
            push_ar(0, 32'h8000_0000, 4'd3, 8'd0);
            rd_beat(0, 32'h0000_0413, 2'b00, 1, 4'd3);
            fork
               mrd(0, 32'h8000_0000, 4'd3, 8'd0);
               begin
                  @(negedge clock); chk("t1_idle", 64'(grant), 64'd0);
                  @(negedge clock); chk("t1_grant", 64'(grant), 64'd1);
                  chk("t1_s_arvalid", 64'(s_arvalid), 64'd1);
                  @(negedge clock); chk("t1_m0_rvalid", 64'(m0_rvalid), 64'd1);
                  @(negedge clock); chk("t1_release", 64'(grant), 64'd0);
               end
            join
            tick();

            // simultaneous requests, M1 first
            push_ar(1, 32'h8000_1000, 4'd2, 8'd0);
            push_ar(0, 32'h8000_0004, 4'd1, 8'd0);
            rd_beat(1, 32'hcafe_0001, 2'b00, 1, 4'd2);
            rd_beat(0, 32'h0000_0013, 2'b00, 1, 4'd1);
            fork
               mrd(0, 32'h8000_0004, 4'd1, 8'd0);
               mrd(1, 32'h8000_1000, 4'd2, 8'd0);
               begin
                  @(negedge clock); chk("t2_idle", 64'(grant), 64'd0);
                  @(negedge clock); chk("t2_m1_first", 64'(grant), 64'd2);
                  @(negedge clock);
                  @(negedge clock); chk("t2_turnaround", 64'(grant), 64'd0);
                  @(negedge clock); chk("t2_m0_next", 64'(grant), 64'd1);
               end
            join
            tick();

            // LSU store, W accepted two cycles before AW
            a0 = cnt_aw; w0 = cnt_w;
            exp_aw.push_back({13'b0, 2'b11, 32'ha000_03f8, 4'd5, 8'd0,
                              3'd0, 2'b01});
            exp_w.push_back({27'b0, 32'h0000_0041, 4'b0001, 1'b1});
            exp_b.push_back({58'b0, 2'b00, 4'd5});
            sl_awready = 0; sl_wready = 1;
            fork
               mwr(32'ha000_03f8, 4'd5, 32'h0000_0041, 4'b0001);
               begin
                  repeat (3) tick();
                  sl_awready = 1;
               end
               begin
                  @(negedge clock); chk("t3_idle", 64'(grant), 64'd0);
                  @(negedge clock); chk("t3_grant", 64'(grant), 64'd3);
                  chk("t3_s_wvalid", 64'(s_wvalid), 64'd1);
                  @(negedge clock); chk("t3_w_done", 64'({s_wvalid, m1_wready}), 64'd0);
                  @(negedge clock); chk("t3_aw", 64'({s_awvalid, s_awready}), 64'd3);
                  @(negedge clock); chk("t3_b", 64'({s_bvalid, s_bready}), 64'd3);
                  @(negedge clock); chk("t3_release", 64'(grant), 64'd0);
               end
            join
            chk("t3_aw_count", 64'(cnt_aw - a0), 64'd1);
            chk("t3_w_count", 64'(cnt_w - w0), 64'd1);
            tick();

            // burst read, M1 request arriving mid-burst waits
            push_ar(0, 32'h8000_0100, 4'd7, 8'd3);
            rd_beat(0, 32'h1111_1111, 2'b00, 0, 4'd7);
            rd_beat(0, 32'h2222_2222, 2'b00, 0, 4'd7);
            rd_beat(0, 32'h3333_3333, 2'b00, 0, 4'd7);
            rd_beat(0, 32'h4444_4444, 2'b00, 1, 4'd7);
            push_ar(1, 32'h8000_2000, 4'd9, 8'd0);
            rd_beat(1, 32'h55aa_55aa, 2'b00, 1, 4'd9);
            fork
               mrd(0, 32'h8000_0100, 4'd7, 8'd3);
               begin
                  repeat (3) tick();
                  mrd(1, 32'h8000_2000, 4'd9, 8'd0);
               end
               begin
                  @(negedge clock); chk("t4_idle", 64'(grant), 64'd0);
                  repeat (5) begin
                     @(negedge clock); chk("t4_hold", 64'(grant), 64'd1);
                  end
                  @(negedge clock); chk("t4_turnaround", 64'(grant), 64'd0);
                  @(negedge clock); chk("t4_m1_after", 64'(grant), 64'd2);
               end
            join
            tick();

            // error response still completes
            push_ar(1, 32'h8000_3000, 4'ha, 8'd0);
            rd_beat(1, 32'hbad0_0000, 2'b10, 1, 4'ha);
            mrd(1, 32'h8000_3000, 4'ha, 8'd0);
            @(negedge clock); chk("t5_release", 64'(grant), 64'd0);
            tick();

            // reset during M1_WR after AW handshake
            exp_aw.push_back({13'b0, 2'b11, 32'h8000_4000, 4'd6, 8'd0,
                              3'd2, 2'b01});
            sl_awready = 1; sl_wready = 0;
            m1_awaddr = 32'h8000_4000; m1_awid = 4'd6; m1_awlen = 8'd0;
            m1_awsize = 3'd2; m1_awburst = 2'b01;
            m1_wdata = 32'h1234_5678; m1_wstrb = 4'hf; m1_wlast = 1;
            m1_awvalid = 1; m1_wvalid = 1; m1_bready = 1;
            @(negedge clock);
            @(negedge clock); chk("t6_grant", 64'(grant), 64'd3);
            chk("t6_aw_hs", 64'({s_awvalid, s_awready}), 64'd3);
            tick();
            reset = 1'b1;
            @(negedge clock);
            chk("t6_aw_done", 64'({s_awvalid, m1_awready}), 64'd0);
            @(negedge clock);
            chk("t6_rst_grant", 64'(grant), 64'd0);
            chk("t6_rst_valids", 64'({s_awvalid, s_wvalid, s_arvalid,
                                      m1_bvalid}), 64'd0);
            chk("t6_rst_readies", 64'({m1_awready, m1_wready, s_bready,
                                       s_rready}), 64'd0);
            tick();
            reset = 1'b0;
            m1_awvalid = 0; m1_wvalid = 0; m1_bready = 0;
            sl_wready = 1;
            tick();
            @(negedge clock); chk("t6_idle_after", 64'(grant), 64'd0);

            chk("queues_drained", 64'(exp_ar.size() + exp_r0.size() +
                exp_r1.size() + exp_aw.size() + exp_w.size() +
                exp_b.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures",
                     n_checks, n_fail);
            $finish;
         end
      join_any
   end

endmodule
